usb_rx_txn_ctrl: RTL

Host-side transaction sequencer that sits above the packet receiver and the transmit path. It launches a token/data packet, opens the receive window, and classifies the device response as ACK, NAK, DATA0 (CRC good/bad) or timeout. It then either completes the transaction (sending the host ACK after good IN data) or retries up to a bounded count, reporting the result to the read/write FSM.

---
 rtl/usb_rx_txn_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/usb_rx_txn_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : usb_rx_txn_ctrl
// Brief    : Host transaction sequencer: send packet, classify the device
//            response (ACK/NAK/DATA0/timeout), host-ACK good IN data, retry.
//            Optional error counter enabled by macro USB_RX_ERR_COUNT_EN.
// Revision : 1.0
// ============================================================================
module usb_rx_txn_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        txn_start,
  input  logic        txn_is_in,
  output logic        tx_req,
  output logic        tx_ack_req,
  input  logic        tx_done,
  input  logic        rec_ACK,
  input  logic        rec_NAK,
  input  logic        rec_DATA0,
  input  logic        data_valid,
  input  logic [63:0] data_rec,
  output logic        rx_enable,
  output logic        busy,
  output logic        txn_done,
  output logic        txn_ok,
  output logic [63:0] txn_data,
  output logic [3:0]  retries_used,
  output logic [7:0]  err_count
);

  localparam int                 c_cnt_w     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         c_max_retry = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_SEND        = 3'd1,
    S_WAIT_TX     = 3'd2,
    S_WAIT_RESP   = 3'd3,
    S_SEND_ACK    = 3'd4,
    S_WAIT_ACK_TX = 3'd5,
    S_RETRY       = 3'd6,
    S_FINISH      = 3'd7
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_is_in;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_ok;
  logic [63:0]        r_data;
  logic [3:0]         r_retries;
  logic               w_finish_ok;
  logic               w_finish_fail;
  logic               w_latch_data;

  always_comb begin
    w_next        = r_state;
    w_finish_ok   = 1'b0;
    w_finish_fail = 1'b0;
    w_latch_data  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (txn_start) w_next = S_SEND;
      end
      S_SEND: w_next = S_WAIT_TX;
      S_WAIT_TX: begin
        if (tx_done) w_next = S_WAIT_RESP;
      end
      S_WAIT_RESP: begin
        // A response in the last window cycle still wins over the timeout
        if (rec_ACK) begin
          if (r_is_in) begin
            w_next = S_RETRY;
          end else begin
            w_next      = S_FINISH;
            w_finish_ok = 1'b1;
          end
        end else if (rec_NAK) begin
          w_next = S_RETRY;
        end else if (rec_DATA0) begin
          if (r_is_in && data_valid) begin
            w_next       = S_SEND_ACK;
            w_latch_data = 1'b1;
          end else begin
            w_next = S_RETRY;
          end
        end else if (r_cnt == c_cnt_last) begin
          w_next = S_RETRY;
        end
      end
      S_SEND_ACK: w_next = S_WAIT_ACK_TX;
      S_WAIT_ACK_TX: begin
        if (tx_done) begin
          w_next      = S_FINISH;
          w_finish_ok = 1'b1;
        end
      end
      S_RETRY: begin
        if (r_retries == c_max_retry) begin
          w_next        = S_FINISH;
          w_finish_fail = 1'b1;
        end else begin
          w_next = S_SEND;
        end
      end
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_is_in   <= 1'b0;
      r_cnt     <= '0;
      r_ok      <= 1'b0;
      r_data    <= '0;
      r_retries <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && txn_start) begin
        r_is_in   <= txn_is_in;
        r_retries <= '0;
        r_ok      <= 1'b0;
      end
      if (r_state == S_WAIT_TX) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT_RESP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_finish_ok) r_ok <= 1'b1;
      if (w_finish_fail) r_ok <= 1'b0;
      // The host ACK always completes, so latching here never exposes data of a failed transaction
      if (w_latch_data) r_data <= data_rec;
      if (r_state == S_RETRY && r_retries != c_max_retry) r_retries <= r_retries + 1'b1;
    end
  end

`ifdef USB_RX_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (r_state == S_WAIT_RESP && w_next == S_RETRY && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign err_count = r_err_count;
`else
  assign err_count = 8'd0;
`endif

  assign tx_req       = (r_state == S_SEND);
  assign tx_ack_req   = (r_state == S_SEND_ACK);
  assign rx_enable    = (r_state == S_WAIT_RESP);
  assign busy         = (r_state != S_IDLE);
  assign txn_done     = (r_state == S_FINISH);
  assign txn_ok       = r_ok;
  assign txn_data     = r_data;
  assign retries_used = r_retries;

endmodule
`default_nettype wire
